// File: rtl/display_7.sv
// Registered hex-nibble to seven-segment decoder with blank/lamp-test overrides.
// Define DISPLAY7_PWM_EN to add a 4-bit free-running PWM brightness gate driven by brillo.
module display_7 #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] palabra,
  input  logic       en,
  input  logic       blank,
  input  logic       lamp_test,
  input  logic [3:0] brillo,
  output logic [6:0] seg
);

  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [3:0] r_nibble;
  logic [6:0] r_seg;
  logic [3:0] w_nibble_next;
  logic [6:0] w_dec_lit;
  logic [6:0] w_sel_lit;
  logic [6:0] w_lit;
  logic [6:0] w_seg_next;
  logic       w_pwm_on;

  // Decoding the next nibble, not r_nibble, gives seg its single-cycle latency.
  assign w_nibble_next = en ? palabra : r_nibble;

  // Lit mask, bit 0 = segment a.
  always_comb begin
    w_dec_lit = 7'h00;
    case (w_nibble_next)
      4'h0: w_dec_lit = 7'h3F;
      4'h1: w_dec_lit = 7'h06;
      4'h2: w_dec_lit = 7'h5B;
      4'h3: w_dec_lit = 7'h4F;
      4'h4: w_dec_lit = 7'h66;
      4'h5: w_dec_lit = 7'h6D;
      4'h6: w_dec_lit = 7'h7D;
      4'h7: w_dec_lit = 7'h07;
      4'h8: w_dec_lit = 7'h7F;
      4'h9: w_dec_lit = 7'h6F;
      4'hA: w_dec_lit = 7'h77;
      4'hB: w_dec_lit = 7'h7C;
      4'hC: w_dec_lit = 7'h39;
      4'hD: w_dec_lit = 7'h5E;
      4'hE: w_dec_lit = 7'h79;
      4'hF: w_dec_lit = 7'h71;
      default: w_dec_lit = 7'h00;
    endcase
  end

  always_comb begin
    w_sel_lit = w_dec_lit;
    if (blank)
      w_sel_lit = 7'h00;
    else if (lamp_test)
      w_sel_lit = 7'h7F;
  end

`ifdef DISPLAY7_PWM_EN
  logic [3:0] r_pwm_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_pwm_cnt <= 4'h0;
    else
      r_pwm_cnt <= r_pwm_cnt + 4'h1;
  end

  assign w_pwm_on = (r_pwm_cnt <= brillo);
`else
  logic w_unused_brillo;

  assign w_unused_brillo = ^brillo;
  assign w_pwm_on        = 1'b1;
`endif

  assign w_lit      = w_sel_lit & {7{w_pwm_on}};
  assign w_seg_next = ACTIVE_LOW ? ~w_lit : w_lit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nibble <= 4'h0;
      r_seg    <= SEG_OFF;
    end else begin
      r_nibble <= w_nibble_next;
      r_seg    <= w_seg_next;
    end
  end

  assign seg = r_seg;

endmodule

// File: tb/tb_display_7.sv
// Scoreboard bench for display_7: driver queues expected seg values, monitor checks them after each edge.
module tb_display_7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] palabra = 4'h0;
  logic       en = 1'b0;
  logic       blank = 1'b0;
  logic       lamp_test = 1'b0;
  logic [3:0] brillo = 4'hF;
  logic [6:0] seg;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [6:0] exp;
    string      name;
  } sb_t;
  sb_t exp_q[$];

  // Expected active-low patterns, index = nibble.
  logic [6:0] pat [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  display_7 #(.ACTIVE_LOW(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .palabra   (palabra),
    .en        (en),
    .blank     (blank),
    .lamp_test (lamp_test),
    .brillo    (brillo),
    .seg       (seg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_total++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input logic [3:0] p, input logic e, input logic b, input logic lt,
                       input logic [6:0] expv, input string name);
    sb_t item;
    @(negedge clk);
    palabra   = p;
    en        = e;
    blank     = b;
    lamp_test = lt;
    item.exp  = expv;
    item.name = name;
    exp_q.push_back(item);
  endtask

  // Monitor: each registered update is compared against the oldest queued expectation.
  initial begin
    sb_t item;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        item = exp_q.pop_front();
        check(item.name, seg, item.exp);
      end
    end
  end

  initial begin
    sb_t item;
    int lit_cnt;
    int off_cnt;
    int bad_cnt;
`ifndef DISPLAY7_PWM_EN
    brillo = 4'h0;
`endif
    // Async reset before any clock edge.
    palabra = 4'h8;
    en      = 1'b1;
    #2 rst_n = 1'b0;
    #1 check("reset_no_clk", seg, 7'b1111111);
    repeat (2) @(posedge clk);
    #1 check("reset_held", seg, 7'b1111111);
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b0;
    item.exp  = pat[0];
    item.name = "reset_nibble_zero";
    exp_q.push_back(item);

    for (int i = 0; i < 16; i++)
      drive(i[3:0], 1'b1, 1'b0, 1'b0, pat[i], $sformatf("sweep_%h", i[3:0]));

    drive(4'h5, 1'b1, 1'b0, 1'b0, pat[5], "hold_load");
    for (int i = 0; i < 3; i++)
      drive(4'h1, 1'b0, 1'b0, 1'b0, pat[5], $sformatf("hold_%0d", i));

    drive(4'h1, 1'b0, 1'b0, 1'b1, 7'b0000000, "lamp_test");
    drive(4'h1, 1'b0, 1'b1, 1'b1, 7'b1111111, "blank_and_lamp");
    drive(4'h1, 1'b0, 1'b0, 1'b0, pat[5], "override_release");
    drive(4'h1, 1'b0, 1'b1, 1'b0, 7'b1111111, "blank_only");
    drive(4'h3, 1'b1, 1'b1, 1'b0, 7'b1111111, "blank_load");
    drive(4'hC, 1'b0, 1'b0, 1'b0, pat[3], "blank_load_release");

    // Mid-operation reset pulse between edges.
    drive(4'h9, 1'b1, 1'b0, 1'b0, pat[9], "pre_reset_9");
    @(negedge clk);
    en = 1'b0;
    #1 rst_n = 1'b0;
    #1 check("reset_mid", seg, 7'b1111111);
    #1 rst_n = 1'b1;
    item.exp  = pat[0];
    item.name = "post_reset_nibble";
    exp_q.push_back(item);
    drive(4'h7, 1'b1, 1'b0, 1'b0, pat[7], "post_reset_7");

    for (int i = 0; i < 8 && exp_q.size() > 0; i++)
      @(posedge clk);
    #2;
    n_total++;
    if (exp_q.size() == 0)
      n_pass++;
    else
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());

`ifdef DISPLAY7_PWM_EN
    @(negedge clk);
    palabra = 4'h8;
    en      = 1'b1;
    brillo  = 4'h3;
    repeat (3) @(posedge clk);
    lit_cnt = 0;
    off_cnt = 0;
    bad_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      if (seg == 7'b0000000) lit_cnt++;
      else if (seg == 7'b1111111) off_cnt++;
      else bad_cnt++;
    end
    n_total++;
    if (lit_cnt == 4 && off_cnt == 12 && bad_cnt == 0)
      n_pass++;
    else
      $display("FAIL pwm_duty: lit=%0d off=%0d other=%0d, required 4/12/0", lit_cnt, off_cnt, bad_cnt);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/display_7.md
DISPLAY_7 -- requirements
Module: display_7

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-002 Parameter ACTIVE_LOW, default 1, SHALL select segment polarity: 1 means a lit segment drives 0; 0 means a lit segment drives 1.
REQ-003 Port clk SHALL be an input, 1 bit wide: rising-edge clock.
REQ-004 Port rst_n SHALL be an input, 1 bit wide: asynchronous active-low reset.
REQ-005 Port palabra SHALL be an input, 4 bits wide: hex nibble to display.
REQ-006 Port en SHALL be an input, 1 bit wide: load enable for palabra.
REQ-007 Port blank SHALL be an input, 1 bit wide: forces all segments off.
REQ-008 Port lamp_test SHALL be an input, 1 bit wide: forces all segments lit.
REQ-009 Port brillo SHALL be an input, 4 bits wide: brightness duty, used only when DISPLAY7_PWM_EN is defined.
REQ-010 Port seg SHALL be an output, 7 bits wide, registered, with bit order {g,f,e,d,c,b,a} (seg[0]=a).

Function
REQ-011 On a rising clk edge with en=1, the block SHALL capture palabra into an internal nibble register; with en=0 the register SHALL hold.
REQ-012 seg SHALL reflect the decode of the captured nibble on the same edge, giving 1-cycle latency from palabra (with en=1) to seg.
REQ-013 The decode SHALL use these lit-segment sets: 0=abcdef, 1=bc, 2=abdeg, 3=abcdg, 4=bcfg, 5=acdfg, 6=acdefg, 7=abc, 8=abcdefg, 9=abcdfg, A=abcefg, b=cdefg, C=adef, d=bcdeg, E=adefg, F=aefg.
REQ-014 With ACTIVE_LOW=1, the resulting seg values SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-015 With ACTIVE_LOW=0, seg SHALL be the bitwise inverse of REQ-014.
REQ-016 The output override priority SHALL be blank > lamp_test > decoded pattern; overrides SHALL also be registered with 1-cycle latency.
REQ-017 When blank and lamp_test are both 1, all segments SHALL be off.
REQ-018 Overrides SHALL NOT alter the nibble register; when an override is released, the stored digit SHALL reappear on the next edge.
REQ-019 The decode SHALL contain no latches and no undefined codes; all 16 inputs SHALL be mapped.

Reset
REQ-020 While rst_n=0, seg SHALL show all segments off (1111111 when ACTIVE_LOW=1), independent of clk.
REQ-021 While rst_n=0, the nibble register SHALL be 0 and the PWM counter SHALL be 0.
REQ-022 On the first rising edge after rst_n deasserts, the block SHALL resume normal sampling per REQ-011.
REQ-023 A reset asserted mid-operation SHALL override every other input immediately.

Configuration
REQ-024 When DISPLAY7_PWM_EN is defined, a free-running 4-bit counter SHALL increment each clk cycle and wrap from 15 to 0.
REQ-025 When DISPLAY7_PWM_EN is defined, lit segments SHALL be driven lit only while counter <= brillo, and shown as off otherwise.
REQ-026 Under DISPLAY7_PWM_EN, brillo=15 SHALL give continuously lit segments and brillo=0 SHALL give a 1/16 duty.
REQ-027 Under DISPLAY7_PWM_EN, blank SHALL still force all segments off, and lamp_test SHALL be subject to PWM.
REQ-028 When DISPLAY7_PWM_EN is undefined, brillo SHALL be ignored, no counter SHALL exist, and lit segments SHALL be continuously lit.

Verification
REQ-029 Reset: rst_n=0 with palabra=4'h8 -> seg=1111111 immediately and with no clock edge needed.
REQ-030 Sweep: en=1, palabra=0..F, one per cycle -> each seg value matches REQ-014 one cycle later (e.g. 4'h2 -> 0100100, 4'hB -> 0000011).
REQ-031 Hold: load 4'h5, set en=0, drive palabra=4'h1 -> seg stays 0010010.
REQ-032 Overrides: lamp_test=1 -> 0000000; then blank=1 as well -> 1111111; release both -> prior digit returns next cycle.
REQ-033 Mid-operation reset: while showing 4'h9, pulse rst_n low between edges -> seg goes to 1111111 at once; after release, 4'h7 with en=1 -> 1111000.
REQ-034 PWM (DISPLAY7_PWM_EN defined): digit 8 with brillo=3 -> seg=0000000 for exactly 4 of every 16 cycles and 1111111 otherwise.
